rs_encoder: RTL and testbench
=============================

// Module: rs_encoder
// PURPOSE
//  Systematic Reed-Solomon encoder, transmit-side counterpart of the syndrome/BM/Chien/Forney decoder chain.
//  Accepts message symbols on an AXI-Stream slave and forwards them unchanged on an AXI-Stream master.
//  After the message it appends ROOTS_NUM parity symbols: the remainder of m(x)*x^ROOTS_NUM mod g(x).
//  Supports shortened codes: message length 1..K_LEN, terminated by s_tlast.
// PARAMETERS
//  SYMB_WIDTH  gf_pkg::SYMB_WIDTH (8)    symbol width, GF(2^SYMB_WIDTH)
//  N_LEN       gf_pkg::N_LEN (255)       full codeword length
//  K_LEN       gf_pkg::K_LEN (239)       maximum message length
//  ROOTS_NUM   N_LEN-K_LEN (16)          parity symbols per codeword; must be >= 2
// PORTS
//  aclk                 in   1            clock
//  areset               in   1            synchronous reset, active-high
//  s_tdata              in   SYMB_WIDTH   message symbol; the first symbol is the highest-degree coefficient
//  s_tvalid             in   1            message symbol valid
//  s_tlast              in   1            last message symbol
//  s_tready             out  1            encoder accepts a symbol
//  m_tdata              out  SYMB_WIDTH   codeword symbol
//  m_tvalid             out  1            codeword symbol valid
//  m_tlast              out  1            last parity symbol of the codeword
//  m_tready             in   1            downstream accepts
//  irq_overlength       out  1            one-cycle pulse: message truncated at K_LEN
// BEHAVIOUR
//  Reset: state=DATA; parity regs, msg_cnt and par_cnt = 0; m_tvalid=0; m_tlast=0; m_tdata=0; irq_overlength=0.
//    A reset in any state, including mid-PARITY, discards the frame. No partial output is emitted after reset.
//  Output stage: one register. out_free = ~m_tvalid | m_tready.
//    m_tvalid/m_tdata/m_tlast change only when out_free.
//  FSM DATA:
//    - s_tready = out_free.
//    - On accept: m_tdata<=s_tdata, m_tvalid<=1, m_tlast<=0.
//    - LFSR update: fb = s_tdata ^ par[ROOTS_NUM-1];
//      par[i] <= par[i-1] ^ gf_mult(fb, G[i]); par[-1] = 0.
//    - msg_cnt++.
//    - Go to PARITY when s_tlast is accepted or msg_cnt reaches K_LEN-1.
//    - If K_LEN is reached without s_tlast: pulse irq_overlength on the same cycle as that accept.
//      The next input symbols then start a new frame after parity.
//    - When out_free=0, nothing is accepted (no latency bubble on the output register).
//  FSM PARITY:
//    - s_tready = 0.
//    - On out_free: m_tdata<=par[ROOTS_NUM-1], then shift par[i]<=par[i-1], par[0]<=0; par_cnt++.
//    - On par_cnt==ROOTS_NUM-1: m_tlast<=1, clear par_cnt and msg_cnt, go to DATA.
//      The parity regs are all zero at this point by construction.
//  Latency: 1 cycle from s_tvalid&s_tready to m_tvalid.
//    Parity follows the last message symbol back-to-back (no idle cycle) when m_tready=1.
//  Throughput: 1 symbol/cycle; a frame of L message symbols occupies the output for L+ROOTS_NUM beats.
//  Backpressure: if m_tvalid=1 and m_tready=0, m_tdata and m_tlast hold stable.
//    The LFSR and counters freeze while held.
//  Arithmetic: all additions are XOR; gf_mult comes from gf_pkg.
//    msg_cnt width is $clog2(K_LEN+1); par_cnt width is $clog2(ROOTS_NUM).
// STRUCTURE
//  gf_pkg additions:
//    - GEN_POLY[ROOTS_NUM-1:0]: generator coefficients (monic term omitted), built at elaboration.
//      Built from pow_first_root over the FIRST_ROOT..FIRST_ROOT+ROOTS_NUM-1 roots, matching the decoder.
//    - enum rs_enc_state_t {ENC_DATA, ENC_PARITY}.
//  Sub-module rs_enc_lfsr:
//    - Holds the parity register array, the constant-multiplier feedback and the shift-out path.
//    - Ports: clk, rst, load (message accept), shift (parity emit), din, dout.
//  rs_encoder holds the FSM, counters and output register.
// TESTING (GF(2^8), poly 0x11D, K_LEN=239, ROOTS_NUM=16)
//  1 Message 239 x 0x00 with tlast on the last symbol -> 255 output beats.
//    The 16 parity symbols are 0x00; m_tlast is set only on beat 255.
//  2 Message of 238 x 0x00 then 0x01 -> parity symbols equal GEN_POLY[15] down to GEN_POLY[0], in order.
//  3 Random 239-symbol message, m_tready random at 50% -> output stream identical to the m_tready=1 run.
//    m_tdata is stable whenever it is held; s_tready=0 throughout PARITY.
//  4 Shortened 10-symbol random message with tlast -> 26 beats.
//    Feed the codeword, zero-prefixed to N_LEN, to the decoder syndrome block -> all syndromes 0x00.
//  5 240 symbols, no tlast -> irq_overlength pulses on beat 239; 16 parity beats follow.
//    Symbol 240 is encoded as the first symbol of the next frame.
//  6 areset asserted on parity beat 5 -> next cycle m_tvalid=0 and s_tready=1.
//    The following frame matches the golden model bit-exactly; two back-to-back frames have no idle gap.

Source files
------------

// File: rtl/rs_encoder_pkg.sv
// Shared definitions for the systematic Reed-Solomon encoder.
// Holds the GF(2^8) arithmetic, the code dimensions, the generator polynomial
// (computed at elaboration time) and the FSM state type.
package rs_encoder_pkg;

  localparam int SYMB_WIDTH = 8;
  localparam int N_LEN      = 255;
  localparam int K_LEN      = 239;
  localparam int ROOTS_NUM  = N_LEN - K_LEN;
  // First consecutive root exponent. It must match the decoder's syndrome block.
  localparam int FIRST_ROOT = 0;
  localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11D;

  localparam int MSG_CNT_W = $clog2(K_LEN + 1);
  localparam int PAR_CNT_W = $clog2(ROOTS_NUM);

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef symb_t [ROOTS_NUM-1:0] gen_poly_t;

  typedef enum logic {ENC_DATA, ENC_PARITY} rs_enc_state_t;

  // Shift-and-add GF multiply, reducing by the primitive polynomial.
  function automatic symb_t gf_mult(symb_t a, symb_t b);
    symb_t acc;
    symb_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[SYMB_WIDTH-1] ? ((sh << 1) ^ PRIM_POLY[SYMB_WIDTH-1:0]) : (sh << 1);
    end
    return acc;
  endfunction

  // alpha^e, used to locate the first generator root.
  function automatic symb_t pow_first_root(int e);
    symb_t r;
    r = symb_t'(1);
    for (int i = 0; i < e; i++) r = gf_mult(r, symb_t'(2));
    return r;
  endfunction

  // g(x) = prod (x + alpha^(FIRST_ROOT+j)); the monic x^ROOTS_NUM term is dropped.
  function automatic gen_poly_t build_gen_poly();
    logic [ROOTS_NUM:0][SYMB_WIDTH-1:0] g;
    symb_t     root;
    gen_poly_t res;
    g    = '0;
    g[0] = symb_t'(1);
    root = pow_first_root(FIRST_ROOT);
    for (int j = 0; j < ROOTS_NUM; j++) begin
      for (int i = j + 1; i > 0; i--) g[i] = g[i-1] ^ gf_mult(g[i], root);
      g[0] = gf_mult(g[0], root);
      root = gf_mult(root, symb_t'(2));
    end
    for (int i = 0; i < ROOTS_NUM; i++) res[i] = g[i];
    return res;
  endfunction

  localparam gen_poly_t GEN_POLY = build_gen_poly();

endpackage

// File: rtl/rs_encoder_lfsr.sv
// Parity LFSR: divides the message by g(x) while symbols are loaded, then
// shifts the remainder out highest-degree first.
module rs_enc_lfsr
  import rs_encoder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [SYMB_WIDTH-1:0] din,
  output logic [SYMB_WIDTH-1:0] dout
);

  gen_poly_t par_q, par_d;
  symb_t     fb;

  assign fb   = din ^ par_q[ROOTS_NUM-1];
  assign dout = par_q[ROOTS_NUM-1];

  // Next remainder: feedback division step on load, plain shift on emit.
  always_comb begin
    par_d = par_q;
    if (load) begin
      par_d[0] = gf_mult(fb, GEN_POLY[0]);
      for (int i = 1; i < ROOTS_NUM; i++) par_d[i] = par_q[i-1] ^ gf_mult(fb, GEN_POLY[i]);
    end else if (shift) begin
      par_d[0] = '0;
      for (int i = 1; i < ROOTS_NUM; i++) par_d[i] = par_q[i-1];
    end
  end

  // Parity register array; reset discards any partial remainder.
  always_ff @(posedge clk) begin
    if (rst) par_q <= '0;
    else     par_q <= par_d;
  end

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS encoder: forwards message symbols unchanged, then appends
// ROOTS_NUM parity symbols. A single output register carries both phases.
// Handshake: a beat transfers on a cycle where valid and ready are both high;
// once m_tvalid is raised, m_tdata/m_tlast hold until m_tready is seen.
module rs_encoder
  import rs_encoder_pkg::*;
(
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [SYMB_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [SYMB_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic                  irq_overlength,
  output rs_enc_state_t         dbg_state_o
);

  rs_enc_state_t         state_q, state_d;
  logic [MSG_CNT_W-1:0]  msg_cnt_q, msg_cnt_d;
  logic [PAR_CNT_W-1:0]  par_cnt_q, par_cnt_d;
  logic [SYMB_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  irq_q, irq_d;
  logic                  out_free, msg_full, load, shift;
  logic [SYMB_WIDTH-1:0] par_out;

  assign out_free = ~tvalid_q | m_tready;
  // The symbol being accepted now is the K_LEN-th of the frame.
  assign msg_full = (msg_cnt_q == MSG_CNT_W'(K_LEN - 1));

  rs_enc_lfsr u_lfsr (
    .clk   (aclk),
    .rst   (areset),
    .load  (load),
    .shift (shift),
    .din   (s_tdata),
    .dout  (par_out)
  );

  // Next-state, output-register and counter logic for the DATA/PARITY FSM.
  always_comb begin
    state_d   = state_q;
    msg_cnt_d = msg_cnt_q;
    par_cnt_d = par_cnt_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    irq_d     = 1'b0;
    s_tready  = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      ENC_DATA: begin
        s_tready = out_free;
        if (out_free) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          if (s_tvalid) begin
            load      = 1'b1;
            tdata_d   = s_tdata;
            tvalid_d  = 1'b1;
            msg_cnt_d = msg_cnt_q + 1'b1;
            irq_d     = msg_full & ~s_tlast;
            if (s_tlast || msg_full) state_d = ENC_PARITY;
          end
        end
      end
      ENC_PARITY: begin
        if (out_free) begin
          shift     = 1'b1;
          tdata_d   = par_out;
          tvalid_d  = 1'b1;
          tlast_d   = 1'b0;
          par_cnt_d = par_cnt_q + 1'b1;
          if (par_cnt_q == PAR_CNT_W'(ROOTS_NUM - 1)) begin
            // Final shift leaves the LFSR all-zero, ready for the next frame.
            tlast_d   = 1'b1;
            par_cnt_d = '0;
            msg_cnt_d = '0;
            state_d   = ENC_DATA;
          end
        end
      end
      default: state_d = ENC_DATA;
    endcase
  end

  // State, counters and the output register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ENC_DATA;
      msg_cnt_q <= '0;
      par_cnt_q <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      msg_cnt_q <= msg_cnt_d;
      par_cnt_q <= par_cnt_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      irq_q     <= irq_d;
    end
  end

  assign m_tdata        = tdata_q;
  assign m_tvalid       = tvalid_q;
  assign m_tlast        = tlast_q;
  assign irq_overlength = irq_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_rs_encoder.sv
// Bench for rs_encoder: table of frames checked through an expected-beat
// queue, plus hand-written overlength, mid-parity reset and back-to-back runs.
module tb_rs_encoder;
  import rs_encoder_pkg::*;

  localparam int R = ROOTS_NUM;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tready = 1'b1;
  logic       irq_overlength;
  rs_enc_state_t dbg_state;

  rs_encoder dut (
    .aclk           (aclk),
    .areset         (areset),
    .s_tdata        (s_tdata),
    .s_tvalid       (s_tvalid),
    .s_tlast        (s_tlast),
    .s_tready       (s_tready),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tlast        (m_tlast),
    .m_tready       (m_tready),
    .irq_overlength (irq_overlength),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] tb_g[0:R];
  bit   sb_en = 1'b1;
  bit   rand_ready = 1'b0;
  int   beats = 0;
  int   cyc = 0;
  int   irq_cnt = 0;
  int   irq_beat = 0;
  int   first_cyc = -1;
  int   last_cyc = -1;
  bit   hold_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  logic [8:0] e;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference GF model ----------------
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      r = r[7] ? ((r << 1) ^ 8'h1D) : (r << 1);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [7:0] tb_alpha(input int ex);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < ex; i++) r = tb_mul(r, 8'h02);
    return r;
  endfunction

  task automatic build_gen();
    logic [7:0] root;
    for (int i = 0; i <= R; i++) tb_g[i] = 8'h00;
    tb_g[0] = 8'h01;
    for (int j = 0; j < R; j++) begin
      root = tb_alpha(FIRST_ROOT + j);
      for (int i = j + 1; i > 0; i--) tb_g[i] = tb_g[i-1] ^ tb_mul(tb_g[i], root);
      tb_g[0] = tb_mul(tb_g[0], root);
    end
  endtask

  // Polynomial long division of m(x)*x^R by g(x).
  task automatic calc_parity(input logic [7:0] m[$], output logic [7:0] p[$]);
    logic [7:0] w[$];
    logic [7:0] c;
    w = m;
    for (int j = 0; j < R; j++) w.push_back(8'h00);
    for (int k = 0; k < m.size(); k++) begin
      c = w[k];
      for (int j = 1; j <= R; j++) w[k+j] = w[k+j] ^ tb_mul(c, tb_g[R-j]);
    end
    p = {};
    for (int j = 0; j < R; j++) p.push_back(w[m.size()+j]);
  endtask

  task automatic push_frame(input logic [7:0] m[$]);
    logic [7:0] p[$];
    calc_parity(m, p);
    for (int k = 0; k < m.size(); k++) exp_q.push_back({1'b0, m[k]});
    for (int j = 0; j < R; j++) exp_q.push_back({1'(j == R - 1), p[j]});
  endtask

  // ---------------- driver ----------------
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      m_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic drive(input logic [7:0] m[$], input bit tlast_end);
    bit hs;
    int guard;
    @(posedge aclk);
    #1;
    for (int k = 0; k < m.size(); k++) begin
      s_tvalid = 1'b1;
      s_tdata  = m[k];
      s_tlast  = tlast_end && (k == m.size() - 1);
      hs = 1'b0;
      guard = 0;
      while (!hs && guard < 1000) begin
        @(negedge aclk);
        hs = s_tready;
        @(posedge aclk);
        #1;
        guard++;
      end
      if (!hs) begin
        check("drive_accept_timeout", 0, 1);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic parity_ready_check();
    for (int i = 0; i < 2000; i++) begin
      @(negedge aclk);
      if (m_tvalid && m_tlast) break;
      check("s_tready_in_parity", int'(s_tready), 0);
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(negedge aclk);
      guard++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (2) @(negedge aclk);
  endtask

  task automatic check_syndromes();
    logic [7:0] a;
    logic [7:0] s;
    for (int j = 0; j < R; j++) begin
      a = tb_alpha(FIRST_ROOT + j);
      s = 8'h00;
      for (int k = 0; k < cap_q.size(); k++) s = tb_mul(s, a) ^ cap_q[k];
      check("syndrome", int'(s), 0);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge aclk) begin
    cyc++;
    if (!areset && sb_en) begin
      if (hold_prev) begin
        check("hold_data", int'(m_tdata), int'(prev_data));
        check("hold_last", int'(m_tlast), int'(prev_last));
      end
      if (irq_overlength) begin
        irq_cnt++;
        irq_beat = beats + 1;
      end
      if (m_tvalid && m_tready) begin
        beats++;
        cap_q.push_back(m_tdata);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_tdata);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", int'(m_tdata), int'(e[7:0]));
          check("beat_last", int'(m_tlast), int'(e[8]));
        end
      end
      hold_prev = m_tvalid && !m_tready;
      prev_data = m_tdata;
      prev_last = m_tlast;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // ---------------- test sequence ----------------
  typedef struct {
    int len;
    int kind;       // 0 zeros, 1 zeros then 0x01, 2 new random, 3 repeat previous
    bit rnd_ready;
    bit syn;
    int exp_beats;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] prev_msg[$];

  initial begin
    logic [7:0] msg[$];
    logic [7:0] m2[$];
    logic [7:0] par[$];

    vecs[0] = '{239, 0, 1'b0, 1'b0, 255};
    vecs[1] = '{239, 1, 1'b0, 1'b0, 255};
    vecs[2] = '{239, 2, 1'b0, 1'b1, 255};
    vecs[3] = '{239, 3, 1'b1, 1'b1, 255};
    vecs[4] = '{10,  2, 1'b0, 1'b1, 26};
    vecs[5] = '{1,   2, 1'b0, 1'b1, 17};

    build_gen();

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_tvalid", int'(m_tvalid), 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("rst_m_tvalid", int'(m_tvalid), 0);
    check("rst_m_tlast", int'(m_tlast), 0);
    check("rst_m_tdata", int'(m_tdata), 0);
    check("rst_irq", int'(irq_overlength), 0);
    check("rst_s_tready", int'(s_tready), 1);

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      msg = {};
      for (int k = 0; k < vecs[v].len; k++) begin
        case (vecs[v].kind)
          0:       msg.push_back(8'h00);
          1:       msg.push_back((k == vecs[v].len - 1) ? 8'h01 : 8'h00);
          3:       msg.push_back(prev_msg[k]);
          default: msg.push_back(8'($urandom_range(0, 255)));
        endcase
      end
      prev_msg   = msg;
      rand_ready = vecs[v].rnd_ready;
      beats      = 0;
      cap_q      = {};
      push_frame(msg);
      drive(msg, 1'b1);
      parity_ready_check();
      wait_drain();
      rand_ready = 1'b0;
      check("beat_count", beats, vecs[v].exp_beats);
      if (vecs[v].kind == 1)
        for (int j = 0; j < R; j++)
          check("genpoly_parity", int'(cap_q[vecs[v].len + j]), int'(tb_g[R-1-j]));
      if (vecs[v].syn) check_syndromes();
    end

    // Overlength: 241 symbols, tlast only on the last one.
    msg = {};
    for (int k = 0; k < 241; k++) msg.push_back(8'($urandom_range(0, 255)));
    m2 = {};
    for (int k = 0; k < 239; k++) m2.push_back(msg[k]);
    push_frame(m2);
    m2 = {};
    for (int k = 239; k < 241; k++) m2.push_back(msg[k]);
    push_frame(m2);
    beats    = 0;
    irq_cnt  = 0;
    irq_beat = 0;
    drive(msg, 1'b1);
    wait_drain();
    check("irq_count", irq_cnt, 1);
    check("irq_beat", irq_beat, 239);
    check("overlength_beats", beats, 239 + R + 2 + R);

    // Reset on parity beat 5 of a 20-symbol frame.
    msg = {};
    for (int k = 0; k < 20; k++) msg.push_back(8'($urandom_range(0, 255)));
    calc_parity(msg, par);
    sb_en = 1'b0;
    drive(msg, 1'b1);
    repeat (6) @(negedge aclk);
    check("pre_reset_valid", int'(m_tvalid), 1);
    check("pre_reset_parity5", int'(m_tdata), int'(par[4]));
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("post_reset_m_tvalid", int'(m_tvalid), 0);
    check("post_reset_s_tready", int'(s_tready), 1);
    repeat (3) @(negedge aclk);
    check("post_reset_idle", int'(m_tvalid), 0);
    sb_en = 1'b1;

    // Two back-to-back frames after reset: no idle gap on the output.
    msg = {};
    for (int k = 0; k < 5; k++) msg.push_back(8'($urandom_range(0, 255)));
    m2 = {};
    for (int k = 0; k < 7; k++) m2.push_back(8'($urandom_range(0, 255)));
    beats     = 0;
    first_cyc = -1;
    last_cyc  = -1;
    push_frame(msg);
    push_frame(m2);
    drive(msg, 1'b1);
    drive(m2, 1'b1);
    wait_drain();
    check("b2b_beats", beats, 5 + 7 + 2 * R);
    check("b2b_span", last_cyc - first_cyc + 1, 5 + 7 + 2 * R);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
